// File: rtl/atctlc2axi500_onehot_wbuf.sv
// Write-side entry buffer with rotating one-hot head/tail pointers feeding a one-hot read mux.
// Optional macro ATCTLC2AXI500_WBUF_FULL_PUSHPOP_EN lets a full buffer push while popping.
module atctlc2axi500_onehot_wbuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned CNTW  = 3
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic               out_pop,
    output logic               out_valid,
    output logic [DEPTH-1:0]   head_ptr,
    output logic [DEPTH-1:0]   tail_ptr,
    output logic [DEPTH*W-1:0] entry_data,
    output logic [DEPTH-1:0]   entry_valid,
    output logic [CNTW-1:0]    count,
    output logic               empty,
    output logic               full
);

    logic [DEPTH-1:0]   head_q, head_d;
    logic [DEPTH-1:0]   tail_q, tail_d;
    logic [DEPTH*W-1:0] data_q, data_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [CNTW-1:0]    count_q, count_d;
    logic               empty_q, empty_d;
    logic               full_q, full_d;

    logic push;
    logic pop;

`ifdef ATCTLC2AXI500_WBUF_FULL_PUSHPOP_EN
    // Combinational out_pop -> in_ready path: a full buffer frees the head slot this cycle.
    assign in_ready = ~full_q | out_pop;
`else
    assign in_ready = ~full_q;
`endif

    assign out_valid = |(valid_q & head_q);
    assign push      = in_valid & in_ready;
    assign pop       = out_pop & out_valid;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (push && tail_q[i]) begin
                data_d[i*W +: W] = in_data;
            end
        end

        // Clear before set so a full push+pop onto the same slot leaves it valid.
        if (pop) begin
            valid_d = valid_d & ~head_q;
            head_d  = {head_q[DEPTH-2:0], head_q[DEPTH-1]};
        end
        if (push) begin
            valid_d = valid_d | tail_q;
            tail_d  = {tail_q[DEPTH-2:0], tail_q[DEPTH-1]};
        end

        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNTW'(1);
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNTW'(DEPTH));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            head_q  <= DEPTH'(1);
            tail_q  <= DEPTH'(1);
            data_q  <= '0;
            valid_q <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign head_ptr    = head_q;
    assign tail_ptr    = tail_q;
    assign entry_data  = data_q;
    assign entry_valid = valid_q;
    assign count       = count_q;
    assign empty       = empty_q;
    assign full        = full_q;

    a_head_onehot : assert property (@(posedge aclk) disable iff (!aresetn)
        $onehot(head_q));
    a_tail_onehot : assert property (@(posedge aclk) disable iff (!aresetn)
        $onehot(tail_q));
    a_ptr_meet : assert property (@(posedge aclk) disable iff (!aresetn)
        (head_q == tail_q) |-> (empty_q || full_q));
    a_popcount : assert property (@(posedge aclk) disable iff (!aresetn)
        CNTW'($countones(valid_q)) == count_q);
    a_count_max : assert property (@(posedge aclk) disable iff (!aresetn)
        count_q <= CNTW'(DEPTH));
    a_out_valid : assert property (@(posedge aclk) disable iff (!aresetn)
        out_valid == ~empty_q);

endmodule

// File: tb/tb_atctlc2axi500_onehot_wbuf.sv
// Directed table-driven bench for atctlc2axi500_onehot_wbuf (DEPTH=4, W=8).
module tb_atctlc2axi500_onehot_wbuf;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned CNTW  = 3;

    logic               aclk;
    logic               aresetn;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_data;
    logic               out_pop;
    logic               out_valid;
    logic [DEPTH-1:0]   head_ptr;
    logic [DEPTH-1:0]   tail_ptr;
    logic [DEPTH*W-1:0] entry_data;
    logic [DEPTH-1:0]   entry_valid;
    logic [CNTW-1:0]    count;
    logic               empty;
    logic               full;

    int checks = 0;
    int errors = 0;

    atctlc2axi500_onehot_wbuf #(
        .DEPTH(DEPTH),
        .W    (W),
        .CNTW (CNTW)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_pop    (out_pop),
        .out_valid  (out_valid),
        .head_ptr   (head_ptr),
        .tail_ptr   (tail_ptr),
        .entry_data (entry_data),
        .entry_valid(entry_valid),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic             iv;
        logic [W-1:0]     d;
        logic             pop;
        logic [DEPTH-1:0] head;
        logic [DEPTH-1:0] tail;
        logic [CNTW-1:0]  cnt;
        logic [DEPTH-1:0] ev;
        logic [31:0]      data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, then release inputs just after the edge.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic pop);
        in_valid = iv;
        in_data  = d;
        out_pop  = pop;
        @(posedge aclk);
        #1;
        in_valid = 1'b0;
        out_pop  = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [DEPTH-1:0] h,
                               input logic [DEPTH-1:0] t, input logic [CNTW-1:0] c,
                               input logic [DEPTH-1:0] ev, input logic [31:0] data);
        check({tag, " head"}, 64'(head_ptr), 64'(h));
        check({tag, " tail"}, 64'(tail_ptr), 64'(t));
        check({tag, " count"}, 64'(count), 64'(c));
        check({tag, " entry_valid"}, 64'(entry_valid), 64'(ev));
        check({tag, " entry_data"}, 64'(entry_data), 64'(data));
        check({tag, " empty"}, 64'(empty), 64'(c == 0));
        check({tag, " full"}, 64'(full), 64'(c == CNTW'(DEPTH)));
        check({tag, " out_valid"}, 64'(out_valid), 64'(c != 0));
        check({tag, " in_ready"}, 64'(in_ready), 64'(c != CNTW'(DEPTH)));
    endtask

    function automatic logic [DEPTH-1:0] rot(input logic [DEPTH-1:0] p);
        return {p[DEPTH-2:0], p[DEPTH-1]};
    endfunction

    task automatic add(input logic iv, input logic [7:0] d, input logic pop,
                       input logic [3:0] h, input logic [3:0] t, input logic [2:0] c,
                       input logic [3:0] ev, input logic [31:0] data);
        vec_t v;
        v.iv = iv; v.d = d; v.pop = pop; v.head = h; v.tail = t;
        v.cnt = c; v.ev = ev; v.data = data;
        vecs.push_back(v);
    endtask

    logic [DEPTH-1:0] eh, et;

    initial begin
        //  iv  data   pop  head     tail     cnt  valid    entry_data
        add(1, 8'h11, 0, 4'b0001, 4'b0010, 3'd1, 4'b0001, 32'h0000_0011);
        add(1, 8'h22, 0, 4'b0001, 4'b0100, 3'd2, 4'b0011, 32'h0000_2211);
        add(1, 8'h33, 0, 4'b0001, 4'b1000, 3'd3, 4'b0111, 32'h0033_2211);
        add(1, 8'h44, 0, 4'b0001, 4'b0001, 3'd4, 4'b1111, 32'h4433_2211);
        add(1, 8'h55, 0, 4'b0001, 4'b0001, 3'd4, 4'b1111, 32'h4433_2211);
        add(0, 8'h00, 1, 4'b0010, 4'b0001, 3'd3, 4'b1110, 32'h4433_2211);
        add(0, 8'h00, 1, 4'b0100, 4'b0001, 3'd2, 4'b1100, 32'h4433_2211);
        add(0, 8'h00, 1, 4'b1000, 4'b0001, 3'd1, 4'b1000, 32'h4433_2211);
        add(0, 8'h00, 1, 4'b0001, 4'b0001, 3'd0, 4'b0000, 32'h4433_2211);
        add(0, 8'h00, 1, 4'b0001, 4'b0001, 3'd0, 4'b0000, 32'h4433_2211);
        add(1, 8'h66, 1, 4'b0001, 4'b0010, 3'd1, 4'b0001, 32'h4433_2266);
        add(1, 8'h77, 0, 4'b0001, 4'b0100, 3'd2, 4'b0011, 32'h4433_7766);

        aresetn  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_pop  = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check_state("reset", 4'b0001, 4'b0001, 3'd0, 4'b0000, 32'h0);

        foreach (vecs[i]) begin
            step(vecs[i].iv, vecs[i].d, vecs[i].pop);
            check_state($sformatf("v%0d", i), vecs[i].head, vecs[i].tail, vecs[i].cnt,
                        vecs[i].ev, vecs[i].data);
        end

        // Steady push+pop at count 2 for 10 cycles.
        eh = 4'b0001;
        et = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 8'h80 + 8'(k), 1'b1);
            eh = rot(eh);
            et = rot(et);
            check($sformatf("steady%0d count", k), 64'(count), 64'd2);
            check($sformatf("steady%0d head", k), 64'(head_ptr), 64'(eh));
            check($sformatf("steady%0d tail", k), 64'(tail_ptr), 64'(et));
        end
        check_state("steady end", 4'b0100, 4'b0001, 3'd2, 4'b1100, 32'h8988_8786);

        // Refill to full, then push+pop together.
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        check_state("refill", 4'b0100, 4'b0100, 3'd4, 4'b1111, 32'h8988_A2A1);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        out_pop  = 1'b1;
        #1;
`ifdef ATCTLC2AXI500_WBUF_FULL_PUSHPOP_EN
        check("full pushpop in_ready", 64'(in_ready), 64'd1);
        step(1'b1, 8'hAA, 1'b1);
        check_state("full pushpop", 4'b1000, 4'b1000, 3'd4, 4'b1111, 32'h89AA_A2A1);
        step(1'b0, 8'h00, 1'b1);
        check_state("pop to 3", 4'b0001, 4'b1000, 3'd3, 4'b0111, 32'h89AA_A2A1);
`else
        check("full pushpop in_ready", 64'(in_ready), 64'd0);
        step(1'b1, 8'hAA, 1'b1);
        check_state("full pushpop", 4'b1000, 4'b0100, 3'd3, 4'b1011, 32'h8988_A2A1);
`endif

        // Asynchronous reset mid-cycle with count 3.
        #2;
        aresetn = 1'b0;
        #1;
        check_state("async reset", 4'b0001, 4'b0001, 3'd0, 4'b0000, 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        check_state("post reset", 4'b0001, 4'b0001, 3'd0, 4'b0000, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
